// File: rtl/wt_dec.sv
// Decimate-by-2 requantiser: keeps even samples, rounds half-up, optionally saturates, buffers in a show-ahead FIFO.
// Optional saturation is enabled by defining WT_DEC_SAT_EN; otherwise the result wraps.
module wt_dec #(
  parameter int pWIDTH = 12,
  parameter int pSHIFT = 12,
  parameter int pDEPTH = 4
) (
  input  logic                  iclk,
  input  logic                  irst_n,
  input  logic                  iclk_ena,
  input  logic                  iena,
  input  logic                  isync,
  input  logic [2*pWIDTH-1:0]   idat,
  input  logic                  ordy,
  output logic                  oena,
  output logic [pWIDTH-1:0]     odat,
  output logic                  osat,
  output logic                  oovf
);

  localparam int AW = $clog2(pDEPTH);
  localparam int SW = 2*pWIDTH + 1;
  localparam logic signed [SW-1:0] RND = SW'(1) << (pSHIFT - 1);

  logic                  phase;
  logic                  take;
  logic                  keep;
  logic signed [SW-1:0]  sum;
  logic signed [SW-1:0]  r;
  logic [pWIDTH-1:0]     q;
  logic                  s1_vld;
  logic [pWIDTH-1:0]     s1_dat;

  logic [pWIDTH-1:0]     mem [pDEPTH];
  logic [AW:0]           wp;
  logic [AW:0]           rp;
  logic                  empty;
  logic                  full;
  logic                  pop;
  logic                  wr_ok;

  assign take = iclk_ena & iena;
  assign keep = take & (~phase | isync);

  // Sign-extend one bit so the rounding add can never overflow.
  assign sum = $signed({idat[2*pWIDTH-1], idat}) + RND;
  assign r   = sum >>> pSHIFT;

`ifdef WT_DEC_SAT_EN
  localparam logic signed [SW-1:0] SMAX = {{(pWIDTH+2){1'b0}}, {(pWIDTH-1){1'b1}}};
  localparam logic signed [SW-1:0] SMIN = {{(pWIDTH+2){1'b1}}, {(pWIDTH-1){1'b0}}};

  logic q_sat;
  logic s1_sat;
  logic unused_bits;

  assign unused_bits = ^sum[pSHIFT-1:0];

  always_comb begin
    q     = r[pWIDTH-1:0];
    q_sat = 1'b0;
    if (r > SMAX) begin
      q     = {1'b0, {(pWIDTH-1){1'b1}}};
      q_sat = 1'b1;
    end else if (r < SMIN) begin
      q     = {1'b1, {(pWIDTH-1){1'b0}}};
      q_sat = 1'b1;
    end
  end

  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      s1_sat <= 1'b0;
      osat   <= 1'b0;
    end else begin
      if (keep) s1_sat <= q_sat;
      // Flag follows the write attempt, whether or not the FIFO accepts it.
      osat <= s1_vld & s1_sat;
    end
  end
`else
  logic unused_bits;

  assign unused_bits = ^{sum[pSHIFT-1:0], r[SW-1:pWIDTH]};
  assign q           = r[pWIDTH-1:0];
  assign osat        = 1'b0;
`endif

  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      phase  <= 1'b0;
      s1_vld <= 1'b0;
      s1_dat <= '0;
    end else begin
      s1_vld <= keep;
      if (take) phase <= isync | ~phase;
      if (keep) s1_dat <= q;
    end
  end

  assign empty = (wp == rp);
  assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign oena  = ~empty;
  assign pop   = oena & ordy;
  // When full, the slot at wp is the head being popped this cycle, so overwriting it is safe.
  assign wr_ok = s1_vld & (~full | pop);
  assign odat  = mem[rp[AW-1:0]];

  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      wp   <= '0;
      rp   <= '0;
      oovf <= 1'b0;
      for (int unsigned i = 0; i < pDEPTH; i++) mem[i] <= '0;
    end else begin
      if (wr_ok) begin
        mem[wp[AW-1:0]] <= s1_dat;
        wp              <= wp + 1'b1;
      end
      if (pop) rp <= rp + 1'b1;
      if (s1_vld & full & ~pop) oovf <= 1'b1;
    end
  end

endmodule

// File: tb/tb_wt_dec.sv
// Directed self-checking bench for wt_dec with default parameters (12-bit out, Q12, depth 4).
module tb_wt_dec;

  logic        iclk;
  logic        irst_n;
  logic        iclk_ena;
  logic        iena;
  logic        isync;
  logic [23:0] idat;
  logic        ordy;
  logic        oena;
  logic [11:0] odat;
  logic        osat;
  logic        oovf;

  int passed;
  int total;

  wt_dec #(.pWIDTH(12), .pSHIFT(12), .pDEPTH(4)) dut (
    .iclk(iclk), .irst_n(irst_n), .iclk_ena(iclk_ena), .iena(iena), .isync(isync),
    .idat(idat), .ordy(ordy), .oena(oena), .odat(odat), .osat(osat), .oovf(oovf)
  );

  initial iclk = 1'b0;
  always #5 iclk = ~iclk;

  task automatic apply_reset();
    irst_n = 1'b0;
    iena = 1'b0; isync = 1'b0; idat = '0; ordy = 1'b0; iclk_ena = 1'b1;
    @(posedge iclk); #1;
    irst_n = 1'b1;
    @(posedge iclk); #1;
  endtask

  // Presents one sample for exactly one edge; returns #1 after that edge.
  task automatic send(input int val, input logic sync);
    idat  = 24'(val);
    isync = sync;
    iena  = 1'b1;
    @(posedge iclk); #1;
    iena  = 1'b0;
    isync = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    total++; if ({oena, osat, oovf} !== 3'b000) $display("FAIL reset_flags got=%b exp=000", {oena, osat, oovf}); else passed++;
    total++; if (odat !== 12'd0) $display("FAIL reset_odat got=%0d exp=0", $signed(odat)); else passed++;
  endtask

  task automatic test_rounding();
    int vin [5] = '{2047, 2048, 6144, -2048, -2049};
    int vexp[5] = '{0, 1, 2, 0, -1};
    apply_reset();
    ordy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      send(vin[i], 1'b1);
      total++; if (oena !== 1'b0) $display("FAIL round_lat%0d oena got=%b exp=0", i, oena); else passed++;
      @(posedge iclk); #1;
      total++;
      if (oena !== 1'b1 || odat !== 12'(vexp[i]))
        $display("FAIL round%0d got oena=%b odat=%0d exp oena=1 odat=%0d", i, oena, $signed(odat), vexp[i]);
      else passed++;
      @(posedge iclk); #1;
    end
  endtask

  task automatic test_decimation();
    int exp1[4] = '{1, 3, 5, 7};
    int exp2[5] = '{1, 2, 4, 6, 8};
    for (int run = 0; run < 2; run++) begin
      int idx = 0;
      int n = (run == 0) ? 4 : 5;
      apply_reset();
      ordy = 1'b1;
      fork
        begin
          for (int k = 1; k <= 8; k++) send(k * 4096, (run == 0) ? (k == 1) : (k == 2));
        end
        begin
          for (int c = 0; c < 30; c++) begin
            @(negedge iclk);
            if (oena && ordy) begin
              int e = (idx < n) ? ((run == 0) ? exp1[idx] : exp2[idx]) : 0;
              total++;
              if (idx >= n || odat !== 12'(e))
                $display("FAIL decim_r%0d_%0d got=%0d exp=%0d", run, idx, $signed(odat), e);
              else passed++;
              idx++;
            end
          end
        end
      join
      total++; if (idx != n) $display("FAIL decim_r%0d_count got=%0d exp=%0d", run, idx, n); else passed++;
    end
  endtask

  task automatic test_saturation();
    apply_reset();
    ordy = 1'b1;
    send(8388607, 1'b1);
    @(posedge iclk); #1;
`ifdef WT_DEC_SAT_EN
    total++; if (odat !== 12'd2047) $display("FAIL sat_pos got=%0d exp=2047", $signed(odat)); else passed++;
    total++; if (osat !== 1'b1) $display("FAIL sat_pos_osat got=%b exp=1", osat); else passed++;
`else
    total++; if (odat !== 12'h800) $display("FAIL wrap_pos got=%0d exp=-2048", $signed(odat)); else passed++;
    total++; if (osat !== 1'b0) $display("FAIL wrap_pos_osat got=%b exp=0", osat); else passed++;
`endif
    @(posedge iclk); #1;
    total++; if (osat !== 1'b0) $display("FAIL sat_pulse_width got=%b exp=0", osat); else passed++;
    // Most negative input rounds to exactly the minimum code: in range, no saturation.
    send(-8388608, 1'b1);
    @(posedge iclk); #1;
    total++; if (odat !== 12'h800) $display("FAIL sat_neg got=%0d exp=-2048", $signed(odat)); else passed++;
    total++; if (osat !== 1'b0) $display("FAIL sat_neg_osat got=%b exp=0", osat); else passed++;
    @(posedge iclk); #1;
  endtask

  task automatic test_backpressure();
    apply_reset();
    ordy = 1'b0;
    for (int k = 1; k <= 5; k++) send(k * 4096, 1'b1);
    total++; if (oena !== 1'b1 || oovf !== 1'b0) $display("FAIL bp_pre got oena=%b oovf=%b exp oena=1 oovf=0", oena, oovf); else passed++;
    @(posedge iclk); #1;
    total++; if (oovf !== 1'b1) $display("FAIL bp_ovf got=%b exp=1", oovf); else passed++;
    ordy = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      total++;
      if (oena !== 1'b1 || odat !== 12'(k)) $display("FAIL bp_drain%0d got oena=%b odat=%0d exp=%0d", k, oena, $signed(odat), k);
      else passed++;
      @(posedge iclk); #1;
    end
    total++; if (oena !== 1'b0 || oovf !== 1'b1) $display("FAIL bp_end got oena=%b oovf=%b exp oena=0 oovf=1", oena, oovf); else passed++;
  endtask

  task automatic test_full_pop();
    apply_reset();
    ordy = 1'b0;
    for (int k = 1; k <= 4; k++) send(k * 4096, 1'b1);
    @(posedge iclk); #1;
    send(5 * 4096, 1'b1);
    ordy = 1'b1;
    @(posedge iclk); #1;
    for (int k = 2; k <= 5; k++) begin
      total++;
      if (oena !== 1'b1 || odat !== 12'(k)) $display("FAIL fullpop%0d got oena=%b odat=%0d exp=%0d", k, oena, $signed(odat), k);
      else passed++;
      @(posedge iclk); #1;
    end
    total++; if (oena !== 1'b0 || oovf !== 1'b0) $display("FAIL fullpop_end got oena=%b oovf=%b exp 0 0", oena, oovf); else passed++;
  endtask

  task automatic test_reset_midstream();
    apply_reset();
    ordy = 1'b0;
    for (int k = 1; k <= 3; k++) send(k * 4096, 1'b1);
    @(posedge iclk); #1;
    total++; if (oena !== 1'b1 || odat !== 12'd1) $display("FAIL mid_pre got oena=%b odat=%0d exp 1 1", oena, $signed(odat)); else passed++;
    irst_n = 1'b0;
    #1;
    total++;
    if (oena !== 1'b0 || odat !== 12'd0 || oovf !== 1'b0)
      $display("FAIL mid_rst got oena=%b odat=%0d oovf=%b exp 0 0 0", oena, $signed(odat), oovf);
    else passed++;
    @(posedge iclk); #1;
    irst_n = 1'b1;
    ordy = 1'b1;
    send(7 * 4096, 1'b0);
    @(posedge iclk); #1;
    total++; if (oena !== 1'b1 || odat !== 12'd7) $display("FAIL mid_first got oena=%b odat=%0d exp 1 7", oena, $signed(odat)); else passed++;
    @(posedge iclk); #1;
  endtask

  task automatic test_clk_ena();
    apply_reset();
    ordy = 1'b1;
    iclk_ena = 1'b0;
    send(9 * 4096, 1'b0);
    iclk_ena = 1'b1;
    @(posedge iclk); #1;
    total++; if (oena !== 1'b0) $display("FAIL clkena_block got=%b exp=0", oena); else passed++;
    send(3 * 4096, 1'b0);
    @(posedge iclk); #1;
    total++; if (oena !== 1'b1 || odat !== 12'd3) $display("FAIL clkena_phase got oena=%b odat=%0d exp 1 3", oena, $signed(odat)); else passed++;
    @(posedge iclk); #1;
  endtask

  initial begin
    passed = 0;
    total  = 0;
    test_reset();
    test_rounding();
    test_decimation();
    test_saturation();
    test_backpressure();
    test_full_pop();
    test_reset_midstream();
    test_clk_ena();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
